// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and constants for the reorder buffer
package rob_pkg;

    localparam int ROB_SIZE          = 16;
    localparam int ROB_IDX_BITS      = $clog2(ROB_SIZE);
    localparam int STORE_BUFFER_SIZE = 4;
    localparam int SB_IDX_BITS       = $clog2(STORE_BUFFER_SIZE);

    localparam logic [31:0] ADDR_XCPT = 32'h0000_2000;

    typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;
    // Extra MSB is the wrap bit used to tell full from empty.
    typedef logic [ROB_IDX_BITS:0]   rob_ptr_t;
    typedef logic [SB_IDX_BITS-1:0]  store_buffer_idx_t;
    typedef logic [5:0]              xcpt_code_t;

    localparam xcpt_code_t XCPT_ILLEGAL_INSTR = 6'b000010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  addr_rd;
        logic        write_enable;
        logic        store_to_mem;
        logic        is_csr;
        logic [31:0] kanata_id;
        logic        xcpt;
        xcpt_code_t  xcpt_code;
        rob_idx_t    rob_idx;
    } instr_data_t;

    typedef struct packed {
        logic              valid;
        instr_data_t       instr;
        logic [31:0]       result;
        logic              branch_taken;
        logic [31:0]       branched_pc;
        store_buffer_idx_t store_buffer_idx;
    } mem_to_wb_t;

    typedef struct packed {
        logic              valid;
        logic              completed;
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [4:0]        addr_rd;
        logic              write_enable;
        logic              store_to_mem;
        logic              is_csr;
        logic [31:0]       kanata_id;
        logic              xcpt;
        xcpt_code_t        xcpt_code;
        logic [31:0]       result;
        logic              branch_taken;
        logic [31:0]       new_pc;
        store_buffer_idx_t store_buffer_idx;
    } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// rtl/rob_if.sv - issue, write-back and retirement signals of the reorder buffer
//   master: issue/write-back/retire consumers (drives alloc_* and wb_i)
//   slave : the reorder buffer itself
interface rob_if;
    import rob_pkg::*;

    logic              alloc_valid_i;
    instr_data_t       alloc_instr_i;
    logic              alloc_ready_o;
    rob_idx_t          alloc_idx_o;
    mem_to_wb_t        wb_i;
    logic              commit_valid_o;
    rob_entry_t        commit_entry_o;
    logic              rf_we_o;
    logic [4:0]        rf_addr_o;
    logic [31:0]       rf_data_o;
    logic              sb_commit_o;
    store_buffer_idx_t sb_commit_idx_o;
    logic              flush_o;
    logic [31:0]       flush_pc_o;
    logic              xcpt_o;
    xcpt_code_t        xcpt_code_o;
    logic [31:0]       xcpt_pc_o;
    logic              full_o;
    logic              empty_o;

    modport master (
        output alloc_valid_i, alloc_instr_i, wb_i,
        input  alloc_ready_o, alloc_idx_o, commit_valid_o, commit_entry_o,
               rf_we_o, rf_addr_o, rf_data_o, sb_commit_o, sb_commit_idx_o,
               flush_o, flush_pc_o, xcpt_o, xcpt_code_o, xcpt_pc_o, full_o, empty_o
    );

    modport slave (
        input  alloc_valid_i, alloc_instr_i, wb_i,
        output alloc_ready_o, alloc_idx_o, commit_valid_o, commit_entry_o,
               rf_we_o, rf_addr_o, rf_data_o, sb_commit_o, sb_commit_idx_o,
               flush_o, flush_pc_o, xcpt_o, xcpt_code_o, xcpt_pc_o, full_o, empty_o
    );
endinterface

// File: rtl/rob.sv
// rtl/rob.sv - in-order retirement reorder buffer
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   bus   : rob_if.slave - allocation at issue, out-of-order completions,
//           in-order commit to register file / store buffer, flush and exceptions
module rob
    import rob_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    rob_if.slave   bus
);

    rob_entry_t entries [ROB_SIZE];
    rob_ptr_t   head;
    rob_ptr_t   tail;

    rob_idx_t   head_idx;
    rob_idx_t   tail_idx;
    rob_idx_t   wb_idx;
    rob_entry_t head_entry;
    rob_entry_t new_entry;
    logic       empty;
    logic       full;
    logic       commit_valid;
    logic       flush;
    logic       alloc_fire;
    logic       wb_hit;

    assign head_idx   = head[ROB_IDX_BITS-1:0];
    assign tail_idx   = tail[ROB_IDX_BITS-1:0];
    assign wb_idx     = bus.wb_i.instr.rob_idx;
    assign head_entry = entries[head_idx];

    assign empty = (head == tail);
    assign full  = (head_idx == tail_idx) && (head[ROB_IDX_BITS] != tail[ROB_IDX_BITS]);

    assign commit_valid = !empty && head_entry.valid && head_entry.completed;
    assign flush        = commit_valid && (head_entry.xcpt || head_entry.branch_taken);
    // Uses full at the start of the cycle: a same-cycle commit frees nothing yet.
    assign alloc_fire   = bus.alloc_valid_i && !full;
    // Write-backs to squashed entries land on invalid slots and are dropped.
    assign wb_hit       = bus.wb_i.valid && entries[wb_idx].valid;

    always_comb begin
        new_entry                  = '0;
        new_entry.valid            = 1'b1;
        // A fetch/decode exception has nothing to wait for.
        new_entry.completed        = bus.alloc_instr_i.xcpt;
        new_entry.pc               = bus.alloc_instr_i.pc;
        new_entry.instr            = bus.alloc_instr_i.instr;
        new_entry.addr_rd          = bus.alloc_instr_i.addr_rd;
        new_entry.write_enable     = bus.alloc_instr_i.write_enable;
        new_entry.store_to_mem     = bus.alloc_instr_i.store_to_mem;
        new_entry.is_csr           = bus.alloc_instr_i.is_csr;
        new_entry.kanata_id        = bus.alloc_instr_i.kanata_id;
        new_entry.xcpt             = bus.alloc_instr_i.xcpt;
        new_entry.xcpt_code        = bus.alloc_instr_i.xcpt_code;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
            end
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            // Everything younger than the retiring entry is squashed,
            // including any same-cycle alloc or write-back.
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
            end
            head <= head + rob_ptr_t'(1);
            tail <= head + rob_ptr_t'(1);
        end else begin
            if (commit_valid) begin
                entries[head_idx].valid <= 1'b0;
                head                    <= head + rob_ptr_t'(1);
            end
            if (alloc_fire) begin
                entries[tail_idx] <= new_entry;
                tail              <= tail + rob_ptr_t'(1);
            end
            if (wb_hit) begin
                entries[wb_idx].completed        <= 1'b1;
                entries[wb_idx].result           <= bus.wb_i.result;
                entries[wb_idx].branch_taken     <= bus.wb_i.branch_taken;
                entries[wb_idx].new_pc           <= bus.wb_i.branched_pc;
                entries[wb_idx].store_buffer_idx <= bus.wb_i.store_buffer_idx;
            end
        end
    end

    assign bus.alloc_ready_o   = !full;
    assign bus.alloc_idx_o     = tail_idx;
    assign bus.full_o          = full;
    assign bus.empty_o         = empty;

    assign bus.commit_valid_o  = commit_valid;
    assign bus.commit_entry_o  = head_entry;

    assign bus.rf_we_o         = commit_valid && !head_entry.xcpt && head_entry.write_enable
                                 && (head_entry.addr_rd != 5'd0);
    assign bus.rf_addr_o       = commit_valid ? head_entry.addr_rd : 5'd0;
    assign bus.rf_data_o       = commit_valid ? head_entry.result : 32'd0;

    assign bus.sb_commit_o     = commit_valid && !head_entry.xcpt && head_entry.store_to_mem;
    assign bus.sb_commit_idx_o = commit_valid ? head_entry.store_buffer_idx : '0;

    assign bus.flush_o         = flush;
    assign bus.flush_pc_o      = !commit_valid        ? 32'd0 :
                                 head_entry.xcpt      ? ADDR_XCPT :
                                 head_entry.branch_taken ? head_entry.new_pc : 32'd0;

    assign bus.xcpt_o          = commit_valid && head_entry.xcpt;
    assign bus.xcpt_code_o     = (commit_valid && head_entry.xcpt) ? head_entry.xcpt_code : '0;
    assign bus.xcpt_pc_o       = (commit_valid && head_entry.xcpt) ? head_entry.pc : 32'd0;

    // Write-back carries the full instruction record; only rob_idx is needed here.
    logic unused_fields;
    assign unused_fields = ^{bus.wb_i.instr, bus.alloc_instr_i.rob_idx};

endmodule

// File: tb/tb_rob.sv
// tb/tb_rob.sv - directed self-checking bench for rob
module tb_rob;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rob_if u_if();

    rob dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.slave)
    );

    function automatic instr_data_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                       input logic we, input logic st,
                                       input logic xc, input xcpt_code_t code);
        instr_data_t r;
        r              = '0;
        r.pc           = pc;
        r.instr        = 32'h0000_0013;
        r.addr_rd      = rd;
        r.write_enable = we;
        r.store_to_mem = st;
        r.xcpt         = xc;
        r.xcpt_code    = code;
        return r;
    endfunction

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input rob_idx_t idx, input logic [31:0] res,
                          input logic tk, input logic [31:0] bpc, input store_buffer_idx_t sbi);
        u_if.wb_i                  = '0;
        u_if.wb_i.valid            = v;
        u_if.wb_i.instr.rob_idx    = idx;
        u_if.wb_i.result           = res;
        u_if.wb_i.branch_taken     = tk;
        u_if.wb_i.branched_pc      = bpc;
        u_if.wb_i.store_buffer_idx = sbi;
    endtask

    task automatic do_reset();
        u_if.alloc_valid_i = 1'b0;
        u_if.alloc_instr_i = '0;
        set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc_one(input instr_data_t ins);
        u_if.alloc_valid_i = 1'b1;
        u_if.alloc_instr_i = ins;
        tick();
        u_if.alloc_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", u_if.empty_o); end
        n_cmp++; if (u_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", u_if.alloc_ready_o); end
        n_cmp++; if (u_if.full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", u_if.full_o); end
        n_cmp++; if (u_if.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_commit: got %b want 0", u_if.commit_valid_o); end
        n_cmp++; if (u_if.flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", u_if.flush_o); end
    endtask

    task automatic test_out_of_order();
        logic [4:0]  exp_rd  [3];
        logic [31:0] exp_dat [3];
        exp_rd  = '{5'd1, 5'd2, 5'd3};
        exp_dat = '{32'h10, 32'h20, 32'h30};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (u_if.alloc_idx_o !== rob_idx_t'(i)) begin n_err++; $display("FAIL ooo_alloc_idx%0d: got %0d want %0d", i, u_if.alloc_idx_o, i); end
            alloc_one(mk(32'h100 + 4 * i, exp_rd[i], 1'b1, 1'b0, 1'b0, '0));
        end
        set_wb(1'b1, 4'd2, 32'h30, 1'b0, '0, '0);
        tick();
        set_wb(1'b1, 4'd0, 32'h10, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL ooo_no_early_commit: got %b want 0", u_if.commit_valid_o); end
        tick();
        set_wb(1'b1, 4'd1, 32'h20, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (u_if.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL ooo_commit%0d_valid: got %b want 1", i, u_if.commit_valid_o); end
            n_cmp++; if (u_if.rf_we_o !== 1'b1) begin n_err++; $display("FAIL ooo_commit%0d_we: got %b want 1", i, u_if.rf_we_o); end
            n_cmp++; if (u_if.rf_addr_o !== exp_rd[i]) begin n_err++; $display("FAIL ooo_commit%0d_rd: got %0d want %0d", i, u_if.rf_addr_o, exp_rd[i]); end
            n_cmp++; if (u_if.rf_data_o !== exp_dat[i]) begin n_err++; $display("FAIL ooo_commit%0d_data: got %h want %h", i, u_if.rf_data_o, exp_dat[i]); end
            tick();
            set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        end
        #1;
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL ooo_empty_after: got %b want 1", u_if.empty_o); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) begin
            n_cmp++; if (u_if.alloc_idx_o !== rob_idx_t'(i)) begin n_err++; $display("FAIL full_alloc_idx%0d: got %0d want %0d", i, u_if.alloc_idx_o, i); end
            alloc_one(mk(32'h200 + 4 * i, 5'd4, 1'b1, 1'b0, 1'b0, '0));
        end
        #1;
        n_cmp++; if (u_if.full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", u_if.full_o); end
        n_cmp++; if (u_if.alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", u_if.alloc_ready_o); end
        // 17th allocation, plus write-back of idx0 in the same cycle.
        set_wb(1'b1, 4'd0, 32'h55, 1'b0, '0, '0);
        alloc_one(mk(32'hdead, 5'd9, 1'b1, 1'b0, 1'b0, '0));
        set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.full_o !== 1'b1) begin n_err++; $display("FAIL full_17th_ignored: got %b want 1", u_if.full_o); end
        n_cmp++; if (u_if.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL full_commit0_valid: got %b want 1", u_if.commit_valid_o); end
        n_cmp++; if (u_if.rf_data_o !== 32'h55) begin n_err++; $display("FAIL full_commit0_data: got %h want 00000055", u_if.rf_data_o); end
        n_cmp++; if (u_if.alloc_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready_during_commit: got %b want 0", u_if.alloc_ready_o); end
        // Allocation in the commit cycle is still refused.
        alloc_one(mk(32'hbeef, 5'd9, 1'b1, 1'b0, 1'b0, '0));
        #1;
        n_cmp++; if (u_if.alloc_ready_o !== 1'b1) begin n_err++; $display("FAIL wrap_ready: got %b want 1", u_if.alloc_ready_o); end
        n_cmp++; if (u_if.alloc_idx_o !== 4'd0) begin n_err++; $display("FAIL wrap_idx: got %0d want 0", u_if.alloc_idx_o); end
        n_cmp++; if (u_if.full_o !== 1'b0) begin n_err++; $display("FAIL wrap_full: got %b want 0", u_if.full_o); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            alloc_one(mk(32'h300 + 4 * i, (i == 3) ? 5'd1 : 5'd7, 1'b1, 1'b0, 1'b0, '0));
        end
        set_wb(1'b1, 4'd5, 32'h5, 1'b0, '0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_wb(1'b1, rob_idx_t'(i), 32'h1, 1'b0, '0, '0);
            tick();
        end
        set_wb(1'b1, 4'd3, 32'h310, 1'b1, 32'h100, '0);
        tick();
        // Same-cycle alloc and write-back must be discarded by the flush.
        set_wb(1'b1, 4'd4, 32'h4, 1'b0, '0, '0);
        u_if.alloc_valid_i = 1'b1;
        u_if.alloc_instr_i = mk(32'h999, 5'd8, 1'b1, 1'b0, 1'b0, '0);
        #1;
        n_cmp++; if (u_if.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL br_commit_valid: got %b want 1", u_if.commit_valid_o); end
        n_cmp++; if (u_if.flush_o !== 1'b1) begin n_err++; $display("FAIL br_flush: got %b want 1", u_if.flush_o); end
        n_cmp++; if (u_if.flush_pc_o !== 32'h100) begin n_err++; $display("FAIL br_flush_pc: got %h want 00000100", u_if.flush_pc_o); end
        n_cmp++; if (u_if.rf_we_o !== 1'b1) begin n_err++; $display("FAIL br_link_we: got %b want 1", u_if.rf_we_o); end
        n_cmp++; if (u_if.rf_data_o !== 32'h310) begin n_err++; $display("FAIL br_link_data: got %h want 00000310", u_if.rf_data_o); end
        n_cmp++; if (u_if.xcpt_o !== 1'b0) begin n_err++; $display("FAIL br_no_xcpt: got %b want 0", u_if.xcpt_o); end
        tick();
        u_if.alloc_valid_i = 1'b0;
        set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL br_empty_after: got %b want 1", u_if.empty_o); end
        n_cmp++; if (u_if.alloc_idx_o !== 4'd4) begin n_err++; $display("FAIL br_new_tail: got %0d want 4", u_if.alloc_idx_o); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (u_if.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL br_squashed_commit%0d: got %b want 0", i, u_if.commit_valid_o); end
            tick();
        end
    endtask

    task automatic test_exception();
        // Continues from the branch flush: head = tail = 4.
        alloc_one(mk(32'h40, 5'd5, 1'b1, 1'b0, 1'b1, XCPT_ILLEGAL_INSTR));
        #1;
        n_cmp++; if (u_if.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL xc_commit_valid: got %b want 1", u_if.commit_valid_o); end
        n_cmp++; if (u_if.rf_we_o !== 1'b0) begin n_err++; $display("FAIL xc_rf_we: got %b want 0", u_if.rf_we_o); end
        n_cmp++; if (u_if.sb_commit_o !== 1'b0) begin n_err++; $display("FAIL xc_sb: got %b want 0", u_if.sb_commit_o); end
        n_cmp++; if (u_if.xcpt_o !== 1'b1) begin n_err++; $display("FAIL xc_xcpt: got %b want 1", u_if.xcpt_o); end
        n_cmp++; if (u_if.xcpt_code_o !== 6'b000010) begin n_err++; $display("FAIL xc_code: got %b want 000010", u_if.xcpt_code_o); end
        n_cmp++; if (u_if.xcpt_pc_o !== 32'h40) begin n_err++; $display("FAIL xc_pc: got %h want 00000040", u_if.xcpt_pc_o); end
        n_cmp++; if (u_if.flush_o !== 1'b1) begin n_err++; $display("FAIL xc_flush: got %b want 1", u_if.flush_o); end
        n_cmp++; if (u_if.flush_pc_o !== 32'h2000) begin n_err++; $display("FAIL xc_flush_pc: got %h want 00002000", u_if.flush_pc_o); end
        tick();
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL xc_empty_after: got %b want 1", u_if.empty_o); end
        n_cmp++; if (u_if.xcpt_o !== 1'b0) begin n_err++; $display("FAIL xc_held_low: got %b want 0", u_if.xcpt_o); end
    endtask

    task automatic test_store_and_x0();
        // Continues from the exception flush: head = tail = 5.
        alloc_one(mk(32'h500, 5'd0, 1'b0, 1'b1, 1'b0, '0));
        alloc_one(mk(32'h504, 5'd0, 1'b1, 1'b0, 1'b0, '0));
        set_wb(1'b1, 4'd5, 32'h0, 1'b0, '0, 2'd2);
        tick();
        set_wb(1'b1, 4'd6, 32'h77, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.sb_commit_o !== 1'b1) begin n_err++; $display("FAIL st_sb_commit: got %b want 1", u_if.sb_commit_o); end
        n_cmp++; if (u_if.sb_commit_idx_o !== 2'd2) begin n_err++; $display("FAIL st_sb_idx: got %0d want 2", u_if.sb_commit_idx_o); end
        n_cmp++; if (u_if.rf_we_o !== 1'b0) begin n_err++; $display("FAIL st_rf_we: got %b want 0", u_if.rf_we_o); end
        n_cmp++; if (u_if.flush_o !== 1'b0) begin n_err++; $display("FAIL st_flush: got %b want 0", u_if.flush_o); end
        tick();
        set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL x0_commit_valid: got %b want 1", u_if.commit_valid_o); end
        n_cmp++; if (u_if.rf_we_o !== 1'b0) begin n_err++; $display("FAIL x0_rf_we: got %b want 0", u_if.rf_we_o); end
        n_cmp++; if (u_if.sb_commit_o !== 1'b0) begin n_err++; $display("FAIL x0_sb: got %b want 0", u_if.sb_commit_o); end
        tick();
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL x0_empty_after: got %b want 1", u_if.empty_o); end
    endtask

    task automatic test_reset_mid_op();
        alloc_one(mk(32'h600, 5'd3, 1'b1, 1'b0, 1'b0, '0));
        set_wb(1'b1, 4'd7, 32'hab, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_wb(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_cmp++; if (u_if.empty_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b want 1", u_if.empty_o); end
        n_cmp++; if (u_if.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_commit: got %b want 0", u_if.commit_valid_o); end
        n_cmp++; if (u_if.alloc_idx_o !== 4'd0) begin n_err++; $display("FAIL rst_mid_tail: got %0d want 0", u_if.alloc_idx_o); end
    endtask

    initial begin
        test_reset();
        test_out_of_order();
        test_full_wrap();
        test_branch_flush();
        test_exception();
        test_store_and_x0();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- In-order retirement stage directly downstream of the write-back path. It consumes mem_to_wb_t completions, which may arrive out of order from the variable-latency execute paths.
- Entries are allocated in program order at issue and retired in program order, at most one per cycle.
- At retirement it drives the register-file write, the store-buffer commit, and the pipeline flush/redirect for taken branches and exceptions.

Parameters:
- ROB_SIZE, 16 (package localparam): number of entries. Must be a power of 2.
- ROB_IDX_BITS, $clog2(ROB_SIZE) (package): entry index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- alloc_valid_i  in  1  issue requests an entry this cycle
- alloc_instr_i  in  instr_data_t  instruction being issued (pc, instr, addr_rd, write_enable, store_to_mem, is_csr, kanata_id, xcpt, xcpt_code)
- alloc_ready_o  out  1  entry available (= !full_o)
- alloc_idx_o  out  ROB_IDX_BITS  index granted (current tail); issue copies it into instr.rob_idx
- wb_i  in  mem_to_wb_t  completion; fields used: valid, instr.rob_idx, result, branch_taken, branched_pc, store_buffer_idx
- commit_valid_o  out  1  head entry retires this cycle
- commit_entry_o  out  rob_entry_t  head entry contents (trace/kanata)
- rf_we_o  out  1  register write enable
- rf_addr_o  out  5  destination register
- rf_data_o  out  32  write data
- sb_commit_o  out  1  release store to memory
- sb_commit_idx_o  out  store_buffer_idx_t  store-buffer slot to release
- flush_o  out  1  flush the front end and the ROB
- flush_pc_o  out  32  redirect PC
- xcpt_o  out  1  exception retired
- xcpt_code_o  out  xcpt_code_t  exception cause
- xcpt_pc_o  out  32  PC of the faulting instruction
- full_o  out  1  all entries valid
- empty_o  out  1  no valid entries

Behaviour:
- Storage: ROB_SIZE x rob_entry_t. Head and tail pointers are ROB_IDX_BITS+1 wide; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
- Reset (rst_i at the edge): all entry valid bits = 0; head = tail = 0.
  - Outputs after reset: commit_valid_o/rf_we_o/sb_commit_o/flush_o/xcpt_o = 0; alloc_ready_o = 1; empty_o = 1; full_o = 0.
  - Reset mid-operation discards all entries with no commit.
- Allocation: when alloc_valid_i && alloc_ready_o (and !flush_o), at the edge:
  - entry[tail] is loaded and marked valid; tail increments, wrapping 15 -> 0.
  - completed = alloc_instr_i.xcpt, so a decode/fetch exception needs no write-back.
  - alloc_ready_o uses full as of the start of the cycle; a same-cycle commit does not free a slot for the same-cycle alloc.
  - Allocation while full is ignored.
- Completion: when wb_i.valid and entry[wb_i.instr.rob_idx] is valid, at the edge it sets completed=1 and captures result, branch_taken, new_pc=branched_pc, store_buffer_idx.
  - A write-back to an invalid entry (squashed) is ignored.
  - A write-back and a commit of different entries in the same cycle are both honoured.
- Commit: combinational from head. commit_valid_o = !empty && entry[head].valid && entry[head].completed. Head increments at the edge.
  - Minimum latency: write-back in cycle N -> commit_valid_o in cycle N+1.
- Commit outputs, when committing a non-exception entry:
  - rf_we_o = write_enable && addr_rd != 0; rf_data_o = result.
  - sb_commit_o = store_to_mem.
- Commit of an entry with xcpt=1:
  - rf_we_o = 0, sb_commit_o = 0.
  - xcpt_o = 1, xcpt_code_o = xcpt_code, xcpt_pc_o = pc.
  - flush_o = 1, flush_pc_o = ADDR_XCPT.
- Commit of an entry with branch_taken=1 (no xcpt):
  - the rd write still occurs (JAL/JALR link).
  - flush_o = 1, flush_pc_o = new_pc.
- Flush: at the edge after flush_o, all valid bits clear and tail = head+1 (the new head).
  - Same-cycle alloc and write-back are discarded.
  - The ROB is empty in the following cycle.
- Outputs are held at 0 when not committing; commit_entry_o is don't-care.

Decomposition:
- rob_entry_t, rob_idx_t, ROB_SIZE, store_buffer_idx_t, xcpt_code_t and ADDR_XCPT already live in the shared package.
- Add to the package: rob_ptr_t (ROB_IDX_BITS+1 bits).
- No sub-module is needed; pointer logic stays inline.

Test Plan:
1. Reset -> empty_o=1, alloc_ready_o=1, full_o=0, commit_valid_o=0, flush_o=0.
2. Allocate add x1/x2/x3 (idx 0,1,2); write back in order 2,0,1 with results 0x30,0x10,0x20 -> commits in order idx0 (x1=0x10), idx1 (x2=0x20), idx2 (x3=0x30).
3. Allocate 16 entries -> full_o=1, alloc_ready_o=0; a 17th alloc is ignored; commit idx0 -> next cycle alloc_ready_o=1 and alloc_idx_o=0 (wrap).
4. Taken branch at idx3 with branched_pc=0x100 while idx4-6 are allocated and idx5 is written back -> commit idx3, flush_o=1, flush_pc_o=0x100; idx4-6 never commit; empty_o=1 the next cycle.
5. Allocate with xcpt=1, code XCPT_ILLEGAL_INSTR, pc=0x40, no write-back -> commit next cycle: rf_we_o=0, xcpt_o=1, xcpt_code_o=6'b000010, xcpt_pc_o=0x40, flush_pc_o=0x2000.
6. Store with store_buffer_idx=2 -> sb_commit_o=1, sb_commit_idx_o=2, rf_we_o=0; instruction with write_enable=1 and rd=x0 -> rf_we_o=0.
